// File: rtl/arm_cpu_pkg.sv
// Shared CPU constants: default datapath widths, the B opcode, and the fetch queue entry layout.
package arm_cpu_pkg;
  localparam int BITSIZE = 32;
  localparam int REGSIZE = 64;

  localparam logic [5:0] OPC_B = 6'b000101;

  typedef struct packed {
    logic [REGSIZE-1:0] pc;
    logic [BITSIZE-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// In-order FIFO between fetch and decode; push/pop/flush with an occupancy count and the head entry.
module fetch_queue #(
  parameter int QDEPTH = 2,
  parameter int DATA_W = 96
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_push,
  input  logic                         i_pop,
  input  logic                         i_flush,
  input  logic [DATA_W-1:0]            i_push_data,
  output logic [$clog2(QDEPTH+1)-1:0]  o_count,
  output logic [DATA_W-1:0]            o_head_data
);
  localparam int CNT_W = $clog2(QDEPTH + 1);
  localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(QDEPTH - 1);

  logic [DATA_W-1:0] r_mem [QDEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;
  logic [PTR_W-1:0]  w_head_nxt;
  logic [PTR_W-1:0]  w_tail_nxt;

  assign w_head_nxt  = (r_head == LAST_PTR) ? '0 : r_head + PTR_W'(1);
  assign w_tail_nxt  = (r_tail == LAST_PTR) ? '0 : r_tail + PTR_W'(1);
  assign o_count     = r_count;
  assign o_head_data = r_mem[r_head];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_tail <= w_tail_nxt;
      if (i_pop)  r_head <= w_head_nxt;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge i_clk) begin
    if (i_push && !i_flush) r_mem[r_tail] <= i_push_data;
  end
endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC register, next-PC selection and queue feed to decode.
// Optional FETCH_EARLY_BRANCH_EN resolves unconditional B (and self-branch halt) inside fetch.
module instruction_fetch_unit #(
  parameter int BITSIZE = arm_cpu_pkg::BITSIZE,
  parameter int REGSIZE = arm_cpu_pkg::REGSIZE,
  parameter int QDEPTH  = 2
) (
  input  logic               Clock,
  input  logic               Reset_n,
  output logic [REGSIZE-1:0] Address,
  input  logic [BITSIZE-1:0] Instruction,
  output logic               OutValid,
  input  logic               OutReady,
  output logic [BITSIZE-1:0] OutInstruction,
  output logic [REGSIZE-1:0] OutPC,
  input  logic               Redirect,
  input  logic [REGSIZE-1:0] RedirectPC,
  output logic               Halted
);
  import arm_cpu_pkg::OPC_B;

  localparam int CNT_W = $clog2(QDEPTH + 1);
  localparam int ENT_W = REGSIZE + BITSIZE;

  logic [REGSIZE-1:0] r_pc;
  logic [CNT_W-1:0]   w_count;
  logic [ENT_W-1:0]   w_head;
  logic               w_deq;
  logic               w_fetch;
  logic               w_push;
  logic [REGSIZE-1:0] w_pc_nxt;
  logic               w_halted;

  assign Address        = r_pc;
  assign OutValid       = (w_count != '0);
  assign OutPC          = w_head[ENT_W-1:BITSIZE];
  assign OutInstruction = w_head[BITSIZE-1:0];
  assign w_deq          = OutValid & OutReady;
  assign w_fetch        = !Redirect & !w_halted & ((w_count != CNT_W'(QDEPTH)) | w_deq);

`ifdef FETCH_EARLY_BRANCH_EN
  logic               r_halted;
  logic               w_is_b;
  logic [REGSIZE-1:0] w_b_off;

  assign w_is_b   = (Instruction[31:26] == OPC_B);
  assign w_b_off  = {{(REGSIZE-26){Instruction[25]}}, Instruction[25:0]};
  assign w_push   = w_fetch & !w_is_b;
  assign w_pc_nxt = w_is_b ? r_pc + w_b_off : r_pc + REGSIZE'(1);
  assign w_halted = r_halted;

  // A zero-offset B would spin forever; park fetch until execute redirects.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n)                                   r_halted <= 1'b0;
    else if (Redirect)                              r_halted <= 1'b0;
    else if (w_fetch && w_is_b && w_b_off == '0)    r_halted <= 1'b1;
  end
`else
  logic [5:0] w_unused_opc;

  assign w_unused_opc = OPC_B;
  assign w_push       = w_fetch;
  assign w_pc_nxt     = r_pc + REGSIZE'(1);
  assign w_halted     = 1'b0;
`endif

  assign Halted = w_halted;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n)      r_pc <= '0;
    else if (Redirect) r_pc <= RedirectPC;
    else if (w_fetch)  r_pc <= w_pc_nxt;
  end

  fetch_queue #(
    .QDEPTH (QDEPTH),
    .DATA_W (ENT_W)
  ) u_queue (
    .i_clk       (Clock),
    .i_rst_n     (Reset_n),
    .i_push      (w_push),
    .i_pop       (w_deq & !Redirect),
    .i_flush     (Redirect),
    .i_push_data ({r_pc, Instruction}),
    .o_count     (w_count),
    .o_head_data (w_head)
  );
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit; branch checks follow FETCH_EARLY_BRANCH_EN.
module tb_instruction_fetch_unit;
  logic        Clock = 1'b0;
  logic        Reset_n;
  logic [63:0] Address;
  logic [31:0] Instruction;
  logic        OutValid;
  logic        OutReady;
  logic [31:0] OutInstruction;
  logic [63:0] OutPC;
  logic        Redirect;
  logic [63:0] RedirectPC;
  logic        Halted;
  logic        br_mode;
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 Clock = ~Clock;

  instruction_fetch_unit dut (
    .Clock          (Clock),
    .Reset_n        (Reset_n),
    .Address        (Address),
    .Instruction    (Instruction),
    .OutValid       (OutValid),
    .OutReady       (OutReady),
    .OutInstruction (OutInstruction),
    .OutPC          (OutPC),
    .Redirect       (Redirect),
    .RedirectPC     (RedirectPC),
    .Halted         (Halted)
  );

  // Asynchronous-read memory: 0x8B010000|addr, with branch words planted at 5 and 8 on demand.
  always_comb begin
    Instruction = 32'h8B01_0000 | Address[31:0];
    if (br_mode && Address == 64'd5) Instruction = 32'h1400_0003;
    if (br_mode && Address == 64'd8) Instruction = 32'h1400_0000;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  initial begin
    Reset_n = 1'b0; OutReady = 1'b1; Redirect = 1'b0; RedirectPC = '0; br_mode = 1'b0;
    #1;
    chk("rst_valid", OutValid, 0);
    chk("rst_addr", Address, 0);
    chk("rst_halted", Halted, 0);
    step(); step();
    chk("rst_hold_addr", Address, 0);

    // Release and stream.
    Reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("stream_valid", OutValid, 1);
      chk("stream_pc", OutPC, 64'(i));
      chk("stream_instr", OutInstruction, 64'(32'h8B01_0000 | i));
    end

    // Backpressure from a fresh start at PC 0.
    OutReady = 1'b0; Redirect = 1'b1; RedirectPC = 64'd0;
    step();
    chk("bp_redir_valid", OutValid, 0);
    chk("bp_redir_addr", Address, 0);
    Redirect = 1'b0;
    step();
    chk("bp_pc0", OutPC, 0);
    chk("bp_addr1", Address, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_full_addr", Address, 2);
      chk("bp_full_pc", OutPC, 0);
      chk("bp_full_valid", OutValid, 1);
    end
    OutReady = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("drain_valid", OutValid, 1);
      chk("drain_pc", OutPC, 64'(i));
      chk("drain_addr", Address, 64'(i + 2));
    end

    // Redirect while full with decode ready.
    Redirect = 1'b1; RedirectPC = 64'h10;
    step();
    chk("rf_valid", OutValid, 0);
    chk("rf_addr", Address, 64'h10);
    Redirect = 1'b0;
    step();
    chk("rf_tgt_valid", OutValid, 1);
    chk("rf_tgt_pc", OutPC, 64'h10);
    chk("rf_tgt_instr", OutInstruction, 64'h8B01_0010);
    chk("rf_next_addr", Address, 64'h11);

    // Branch word at PC 5.
    br_mode = 1'b1; Redirect = 1'b1; RedirectPC = 64'd5;
    step();
    chk("br_redir_addr", Address, 5);
    Redirect = 1'b0;
    step();
`ifdef FETCH_EARLY_BRANCH_EN
    chk("eb_not_emitted", OutValid, 0);
    chk("eb_target", Address, 8);
    step();
    chk("eb_halted", Halted, 1);
    chk("eb_halt_addr", Address, 8);
    chk("eb_halt_valid", OutValid, 0);
    step();
    chk("eb_stuck_addr", Address, 8);
    chk("eb_stuck_halted", Halted, 1);
    br_mode = 1'b0; Redirect = 1'b1; RedirectPC = 64'd0;
    step();
    chk("eb_clear_halted", Halted, 0);
    chk("eb_clear_addr", Address, 0);
    Redirect = 1'b0;
    step();
    chk("eb_resume_pc", OutPC, 0);
`else
    br_mode = 1'b0;
    chk("b_emitted_valid", OutValid, 1);
    chk("b_emitted_pc", OutPC, 5);
    chk("b_emitted_instr", OutInstruction, 64'h1400_0003);
    chk("b_next_addr", Address, 6);
    chk("b_halted", Halted, 0);
    step();
    chk("b_follow_pc", OutPC, 6);
`endif

    // Mid-stream asynchronous reset.
    step();
    #2;
    Reset_n = 1'b0;
    #1;
    chk("mrst_valid", OutValid, 0);
    chk("mrst_addr", Address, 0);
    chk("mrst_halted", Halted, 0);
    step();
    Reset_n = 1'b1;
    step();
    chk("mrst_restart_valid", OutValid, 1);
    chk("mrst_restart_pc0", OutPC, 0);
    step();
    chk("mrst_restart_pc1", OutPC, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Fetch stage that owns the program counter and sits directly upstream of the asynchronous-read instruction memory. It drives the word address, captures the returned instruction with its PC into a small in-order queue, and presents entries to decode over a valid/ready handshake. Redirects from the execute stage flush the queue and reload the PC. An optional predecoder resolves unconditional `B` inside fetch.

## Interface
- `BITSIZE`, default 32: instruction width.
- `REGSIZE`, default 64: PC and address width. The address is a word index, and branch offsets count in words.
- `QDEPTH`, default 2: queue entries. Must be ≥1.

Ports:
- `Clock`, input, 1: sole clock. All state changes on the rising edge.
- `Reset_n`, input, 1: asynchronous, active-low reset.
- `Address`, output, `REGSIZE`: current PC, driven to instruction memory.
- `Instruction`, input, `BITSIZE`: memory data for `Address`, valid in the same cycle.
- `OutValid`, output, 1: head queue entry is valid.
- `OutReady`, input, 1: decode accepts the head entry.
- `OutInstruction`, output, `BITSIZE`: head entry instruction.
- `OutPC`, output, `REGSIZE`: head entry PC.
- `Redirect`, input, 1: execute-stage PC override.
- `RedirectPC`, input, `REGSIZE`: redirect target.
- `Halted`, output, 1: a self-branch was detected. This output is tied to 0 unless `FETCH_EARLY_BRANCH_EN` is defined.

## Operation
- **State:** `PC`; queue storage; head/tail pointers; `count` in the range 0..`QDEPTH`; `Halted`.
- **Address:** `Address = PC`, driven directly from the register.
- **Head outputs:** `OutValid = (count != 0)`. `OutInstruction`/`OutPC` come from the head entry and are undefined-but-stable while `OutValid` = 0.
- **Dequeue:** `deq = OutValid & OutReady`.
- **Fetch:** `fetch = !Redirect & !Halted & (count < QDEPTH | deq)`.
  - On `fetch`, enqueue {PC, Instruction} and set PC ← PC+1, wrapping modulo 2^`REGSIZE`.
  - With no `fetch`, PC holds.
- **Simultaneous enqueue and dequeue:** `count` is unchanged. This sustains one instruction per cycle even when the queue is full.
- **Full:** with `count == QDEPTH` and no `deq`, nothing is fetched and `Address` is stable.
- **Empty:** `OutValid` = 0. `OutReady` is ignored.
- **Redirect:** takes priority over everything else.
  - Flush the queue: pointers and `count` go to 0.
  - PC ← `RedirectPC`. Clear `Halted`.
  - No enqueue that cycle. A same-cycle `deq` is discarded; decode must not depend on it.
- **Queue pointers:** wrap at `QDEPTH`. The queue is strictly in order, with no duplication or loss.

## Timing
- **Reset values:** `PC` = 0, `Address` = 0, `count` = 0, `OutValid` = 0, `Halted` = 0, pointers = 0.
- **Reset assertion:** asynchronous. Outputs reach their reset values immediately, including mid-stream.
- **Reset release:** the first rising edge after release fetches PC 0, and `OutValid` = 1 after that edge.
- **Fetch-to-decode latency:** 1 cycle. An entry enqueued at edge N is visible at the head after edge N if the queue was empty.
- **Redirect timing:** `Redirect` sampled at edge N gives `OutValid` = 0 and `Address = RedirectPC` after N. The target entry appears after N+1.
- **Throughput:** 1 instruction per cycle while `OutReady` stays high.

## Configuration
- **`FETCH_EARLY_BRANCH_EN` defined:**
  - On `fetch`, a fetched `Instruction[31:26] == 6'b000101` is consumed in fetch and not enqueued.
  - PC ← PC + sign-extended `Instruction[25:0]`.
  - If that offset is 0, PC is unchanged and `Halted` ← 1. No further fetches occur until `Redirect` or reset.
- **`FETCH_EARLY_BRANCH_EN` undefined:** `B` is enqueued like any other instruction, PC ← PC+1, and `Halted` is constant 0.

## Structure
- **Shared package `arm_cpu_pkg`:** `BITSIZE`/`REGSIZE` constants, opcode constant `OPC_B` = 6'b000101, and the `fetch_entry_t` struct {pc, instr}.
- **Sub-module `fetch_queue`:** parameterised by `QDEPTH`, with push/pop/flush, `count`, and head data. PC, next-PC mux and predecode stay in the top module.

## Test plan
- **Release and stream:** release reset with `OutReady` = 1 and memory returning 0x8B010000|addr. Expect `OutPC` = 0,1,2,3 on consecutive cycles with matching instructions, and first `OutValid` 1 cycle after release.
- **Backpressure:** hold `OutReady` = 0 for 4 cycles. Expect `count` to saturate at 2, `Address` to hold at 2, and `OutPC` to hold at 0. Then raise `OutReady`: expect `OutPC` 0,1,2,3 with no gap, duplicate or loss.
- **Redirect while full:** assert `Redirect` with `RedirectPC` = 0x10 while the queue is full and `OutReady` = 1. Next cycle expect `OutValid` = 0 and `Address` = 0x10. The cycle after, expect `OutPC` = 0x10.
- **Early branch, macro on:** fetch 0x14000003 at PC 5. Expect it not emitted and the next `Address` = 8. Fetch 0x14000000 at 8: expect `Halted` = 1 and `Address` stuck at 8. A redirect to 0 clears `Halted`.
- **Branch, macro off:** the same 0x14000003 at PC 5 is emitted with `OutPC` = 5, the next `Address` = 6, and `Halted` stays 0.
- **Mid-stream reset:** drop `Reset_n` between edges mid-stream. Expect `OutValid` = 0, `Address` = 0 and `Halted` = 0 immediately. After release, streaming restarts from PC 0.
